// File: rtl/switch_debounce_if.sv
// Switch-conditioning bundle: raw switch levels in, debounced code plus strobes out.
`timescale 1ns/1ps
interface switch_debounce_if #(
    parameter int WIDTH = 2
);
    logic [WIDTH-1:0] switch_in;
    logic [WIDTH-1:0] switch_out;
    logic             changed;
    logic             busy;

    modport master (output switch_in, input switch_out, changed, busy);
    modport slave  (input switch_in, output switch_out, changed, busy);
endinterface

// File: rtl/switch_debounce.sv
// Two-flop synchroniser followed by a vector debounce FSM; a new switch code is
// accepted only after DEBOUNCE_CYCLES consecutive identical synchronised samples.
`timescale 1ns/1ps
module switch_debounce #(
    parameter int WIDTH           = 2,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_W           = 16
) (
    input  logic              clk,
    input  logic              reset,
    switch_debounce_if.slave  sw
);
    typedef enum logic {STABLE, COUNT} state_t;

    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] C_ONE  = CNT_W'(1);

    logic [WIDTH-1:0] r_sync1;
    logic [WIDTH-1:0] r_sync2;
    logic [WIDTH-1:0] r_switch_out;
    logic [WIDTH-1:0] r_cand;
    logic [CNT_W-1:0] r_cnt;
    logic             r_changed;
    logic             r_busy;
    state_t           r_state;

    state_t           w_state_nxt;
    logic [WIDTH-1:0] w_cand_nxt;
    logic [WIDTH-1:0] w_out_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_changed_nxt;

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        w_state_nxt   = r_state;
        w_cand_nxt    = r_cand;
        w_out_nxt     = r_switch_out;
        w_cnt_nxt     = r_cnt;
        w_changed_nxt = 1'b0;
        case (r_state)
            STABLE: begin
                w_cnt_nxt = '0;
                if (r_sync2 != r_switch_out) begin
                    w_cand_nxt  = r_sync2;
                    w_cnt_nxt   = C_ONE;
                    w_state_nxt = COUNT;
                end
            end
            COUNT: begin
                if (r_sync2 == r_switch_out) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = STABLE;
                end else if (r_sync2 != r_cand) begin
                    w_cand_nxt = r_sync2;
                    w_cnt_nxt  = C_ONE;
                end else if (r_cnt == C_LAST) begin
                    w_out_nxt     = r_cand;
                    w_changed_nxt = 1'b1;
                    w_cnt_nxt     = '0;
                    w_state_nxt   = STABLE;
                end else begin
                    w_cnt_nxt = r_cnt + C_ONE;
                end
            end
            default: begin
                w_cnt_nxt   = '0;
                w_state_nxt = STABLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync1      <= '0;
            r_sync2      <= '0;
            r_switch_out <= '0;
            r_cand       <= '0;
            r_cnt        <= '0;
            r_changed    <= 1'b0;
            r_busy       <= 1'b0;
            r_state      <= STABLE;
        end else begin
            r_sync1      <= sw.switch_in;
            r_sync2      <= r_sync1;
            r_switch_out <= w_out_nxt;
            r_cand       <= w_cand_nxt;
            r_cnt        <= w_cnt_nxt;
            r_changed    <= w_changed_nxt;
            r_busy       <= (w_state_nxt == COUNT);
            r_state      <= w_state_nxt;
        end
    end

    assign sw.switch_out = r_switch_out;
    assign sw.changed    = r_changed;
    assign sw.busy       = r_busy;
endmodule
